// File: rtl/xor_accum_stream.sv
// xor_accum_stream: folds LANES lane words per beat by XOR, XOR-accumulates
// the folded words across a frame, and returns the checksum and a saturating
// beat count on a valid/ready result handshake.
// Optional build macro XOR_ACCUM_STREAM_CHECK_EN adds expect_in/err_out, which
// compare the final checksum against an expected value.
module xor_accum_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [LANES*WIDTH-1:0]   data_in,
    input  logic                     valid_in,
    input  logic                     last_in,
    output logic                     ready_out,
    output logic [WIDTH-1:0]         sum_out,
    output logic [CNT_W-1:0]         count_out,
    output logic                     ovf_out,
    output logic                     valid_out,
    input  logic                     ready_in
`ifdef XOR_ACCUM_STREAM_CHECK_EN
    ,
    input  logic [WIDTH-1:0]         expect_in,
    output logic                     err_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [WIDTH-1:0] fold;
    logic [WIDTH-1:0] acc_fold;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_inc;
    logic             accept;

    // XOR all lane words of the current beat together
    always_comb begin
        fold = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            fold = fold ^ data_in[k*WIDTH +: WIDTH];
        end
    end

    // Saturating count step; a beat past the ceiling sets the sticky overflow
    always_comb begin
        acc_fold = acc ^ fold;
        cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        ovf_inc  = ovf | (cnt == CNT_MAX);
    end

    // Input is refused only while a result waits for downstream
    assign ready_out = (state != HOLD);
    assign accept    = valid_in & ready_out;

    // Frame FSM with accumulator, counter and registered result outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            sum_out   <= '0;
            count_out <= '0;
            ovf_out   <= 1'b0;
            valid_out <= 1'b0;
`ifdef XOR_ACCUM_STREAM_CHECK_EN
            err_out   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (last_in) begin
                            sum_out   <= fold;
                            count_out <= CNT_ONE;
                            ovf_out   <= 1'b0;
                            valid_out <= 1'b1;
`ifdef XOR_ACCUM_STREAM_CHECK_EN
                            err_out   <= (fold != expect_in);
`endif
                            state     <= HOLD;
                        end else begin
                            acc   <= fold;
                            cnt   <= CNT_ONE;
                            ovf   <= 1'b0;
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (last_in) begin
                            sum_out   <= acc_fold;
                            count_out <= cnt_inc;
                            ovf_out   <= ovf_inc;
                            valid_out <= 1'b1;
`ifdef XOR_ACCUM_STREAM_CHECK_EN
                            err_out   <= (acc_fold != expect_in);
`endif
                            state     <= HOLD;
                        end else begin
                            acc <= acc_fold;
                            cnt <= cnt_inc;
                            ovf <= ovf_inc;
                        end
                    end
                end
                HOLD: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        ovf_out   <= 1'b0;
`ifdef XOR_ACCUM_STREAM_CHECK_EN
                        err_out   <= 1'b0;
`endif
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_accum_stream.sv
// Directed self-checking bench for xor_accum_stream (WIDTH=8, LANES=2, CNT_W=8).
// Compile with XOR_ACCUM_STREAM_CHECK_EN defined to also exercise expect_in/err_out.
module tb_xor_accum_stream;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic        valid_in;
    logic        last_in;
    logic        ready_out;
    logic [7:0]  sum_out;
    logic [7:0]  count_out;
    logic        ovf_out;
    logic        valid_out;
    logic        ready_in;
`ifdef XOR_ACCUM_STREAM_CHECK_EN
    logic [7:0]  expect_in;
    logic        err_out;
`endif

    int errors = 0;
    int checks = 0;

    xor_accum_stream #(.WIDTH(8), .LANES(2), .CNT_W(8)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .data_in   (data),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .ready_out (ready_out),
        .sum_out   (sum_out),
        .count_out (count_out),
        .ovf_out   (ovf_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
`ifdef XOR_ACCUM_STREAM_CHECK_EN
        ,
        .expect_in (expect_in),
        .err_out   (err_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat (lane1 in the high byte) and hold it for one accepting edge
    task automatic beat(input logic [7:0] lane0, input logic [7:0] lane1, input logic last);
        int n = 0;
        while (ready_out !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (ready_out !== 1'b1) check("ready_timeout", 32'(ready_out), 32'd1);
        data     = {lane1, lane0};
        valid_in = 1'b1;
        last_in  = last;
        @(posedge clk); #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic handshake();
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] s, input logic [7:0] c,
                                input logic o);
        check({tag, "_valid"}, 32'(valid_out), 32'd1);
        check({tag, "_sum"},   32'(sum_out),   32'(s));
        check({tag, "_count"}, 32'(count_out), 32'(c));
        check({tag, "_ovf"},   32'(ovf_out),   32'(o));
        check({tag, "_ready"}, 32'(ready_out), 32'd0);
    endtask

    initial begin
        logic [7:0] model;
        logic [7:0] l0;
        logic [7:0] l1;

        rst_n    = 1'b0;
        data     = '0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        ready_in = 1'b0;
`ifdef XOR_ACCUM_STREAM_CHECK_EN
        expect_in = '0;
`endif
        #12;
        check("rst_sum",   32'(sum_out),   32'd0);
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_ovf",   32'(ovf_out),   32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
`ifdef XOR_ACCUM_STREAM_CHECK_EN
        check("rst_err",   32'(err_out),   32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_ready", 32'(ready_out), 32'd1);

        // Two-beat frame: 0x0F^0xF0 ^ 0x55^0xAA = 0x00
        beat(8'h0F, 8'hF0, 1'b0);
        check("f1_mid_valid", 32'(valid_out), 32'd0);
        beat(8'h55, 8'hAA, 1'b1);
        check_result("f1", 8'h00, 8'd2, 1'b0);
        handshake();
        check("f1_hs_valid", 32'(valid_out), 32'd0);
        check("f1_hs_ready", 32'(ready_out), 32'd1);

        // Single-beat frame, then stall in HOLD with a beat offered (must be ignored)
        beat(8'h12, 8'h34, 1'b1);
        check_result("f2", 8'h26, 8'd1, 1'b0);
        data     = 16'hFFFF;
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(valid_out), 32'd1);
            check("hold_sum",   32'(sum_out),   32'h26);
            check("hold_count", 32'(count_out), 32'd1);
            check("hold_ready", 32'(ready_out), 32'd0);
        end
        valid_in = 1'b0;
        handshake();
        check("f2_hs_valid", 32'(valid_out), 32'd0);
        check("f2_hs_ready", 32'(ready_out), 32'd1);

        // Frame with idle gaps between beats: 0x03 ^ 0x30 = 0x33
        beat(8'h01, 8'h02, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("gap_valid", 32'(valid_out), 32'd0);
        check("gap_ready", 32'(ready_out), 32'd1);
        beat(8'h10, 8'h20, 1'b1);
        check_result("gap", 8'h33, 8'd2, 1'b0);
        handshake();

        // Reset mid-frame after 3 beats: outputs clear asynchronously
        beat(8'h11, 8'h22, 1'b0);
        beat(8'h44, 8'h88, 1'b0);
        beat(8'h0C, 8'h03, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_sum",   32'(sum_out),   32'd0);
        check("mrst_count", 32'(count_out), 32'd0);
        check("mrst_valid", 32'(valid_out), 32'd0);
        check("mrst_ready", 32'(ready_out), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat(8'hAA, 8'h00, 1'b1);
        check_result("post_rst", 8'hAA, 8'd1, 1'b0);
        handshake();

        // Exactly 255 beats: count reaches the ceiling without overflow
        model = '0;
        for (int i = 1; i <= 255; i++) begin
            l0 = 8'(i * 37 + 5);
            l1 = 8'(i * 11);
            model = model ^ l0 ^ l1;
            beat(l0, l1, (i == 255));
        end
        check_result("f255", model, 8'd255, 1'b0);
        handshake();

        // 300 beats: count saturates and overflow is flagged
        model = '0;
        for (int i = 1; i <= 300; i++) begin
            l0 = 8'($urandom);
            l1 = 8'($urandom);
            model = model ^ l0 ^ l1;
            beat(l0, l1, (i == 300));
        end
        check_result("f300", model, 8'd255, 1'b1);
        handshake();
        check("f300_ovf_clr", 32'(ovf_out), 32'd0);

`ifdef XOR_ACCUM_STREAM_CHECK_EN
        expect_in = 8'h26;
        beat(8'h12, 8'h34, 1'b1);
        check_result("chk_ok", 8'h26, 8'd1, 1'b0);
        check("chk_ok_err", 32'(err_out), 32'd0);
        handshake();
        expect_in = 8'h27;
        beat(8'h12, 8'h34, 1'b1);
        check("chk_bad_err", 32'(err_out), 32'd1);
        handshake();
        check("chk_err_clr", 32'(err_out), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
